// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: shared state encoding and defaults for the Wishbone master.
package rv32_wb_pkg;
    typedef enum logic [1:0] {WB_IDLE, WB_BUS, WB_DONE} wb_state_t;
    localparam logic [3:0] WB_REGION_DEFAULT = 4'h2;
endpackage

// File: rtl/rv32_wb_watchdog.sv
// rv32_wb_watchdog: saturating bus-cycle counter that flags the last allowed cycle.
module rv32_wb_watchdog #(
    parameter int LIMIT = 255,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_cnt <= '0;
        else if (clr_i)
            r_cnt <= '0;
        else if (en_i && r_cnt != W'(LIMIT))
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires during the LIMIT-th enabled cycle so termination lands on that edge.
    assign expired_o = en_i && r_cnt == W'(LIMIT - 1);
endmodule

// File: rtl/rv32_wishbone_master.sv
// rv32_wishbone_master: single-outstanding Wishbone B4 classic master for memory-stage
// loads/stores in one address window, with a watchdog against absent slaves.
module rv32_wishbone_master
    import rv32_wb_pkg::*;
#(
    parameter logic [3:0] WB_REGION = WB_REGION_DEFAULT,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_access_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  byte_en_i,
    output logic        stall_o,
    output logic [31:0] read_data_wishbone_o,
    output logic        bus_error_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    wb_state_t   r_state;
    logic [31:0] r_adr, r_dat, r_rdata;
    logic [3:0]  r_sel;
    logic        r_we, r_err;
    logic        w_hit, w_expired, w_fail;

    assign w_hit  = mem_access_i && addr_i[31:28] == WB_REGION;
    assign w_fail = wb_err_i || (w_expired && !wb_ack_i);

    rv32_wb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (r_state != WB_BUS),
        .en_i     (r_state == WB_BUS),
        .expired_o(w_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= WB_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                WB_IDLE: if (w_hit) begin
                    r_adr   <= addr_i & 32'hFFFF_FFFC;
                    r_dat   <= write_data_i;
                    r_sel   <= mem_write_i ? byte_en_i : 4'hF;
                    r_we    <= mem_write_i;
                    r_err   <= 1'b0;
                    r_state <= WB_BUS;
                end
                WB_BUS: if (w_fail || wb_ack_i) begin
                    if (!r_we)
                        r_rdata <= w_fail ? 32'h0 : wb_dat_i;
                    r_err   <= w_fail;
                    r_state <= WB_DONE;
                end
                // DONE always retires; the held inputs belong to the finishing instruction.
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    assign stall_o              = !rst_i && ((r_state == WB_IDLE && w_hit) || r_state == WB_BUS);
    assign wb_cyc_o             = r_state == WB_BUS;
    assign wb_stb_o             = r_state == WB_BUS;
    assign wb_we_o              = r_we;
    assign wb_adr_o             = r_adr;
    assign wb_dat_o             = r_dat;
    assign wb_sel_o             = r_sel;
    assign read_data_wishbone_o = r_rdata;
    assign bus_error_o          = r_state == WB_DONE && r_err;
endmodule

// File: tb/tb_rv32_wishbone_master.sv
// tb_rv32_wishbone_master: transaction-level model of the master, compared every cycle.
module tb_rv32_wishbone_master;
    localparam int T = 8;

    logic        clk_i = 0, rst_i = 1, mem_access_i = 0, mem_write_i = 0;
    logic [31:0] addr_i = 0, write_data_i = 0, wb_dat_i = 0;
    logic [3:0]  byte_en_i = 0;
    logic        wb_ack_i = 0, wb_err_i = 0;
    logic        stall_o, bus_error_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] read_data_wishbone_o, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;

    int vec = 0, errs = 0, stall_cnt = 0;
    bit chk_en = 0;
    logic        e_stall = 0, e_cyc = 0, e_we = 0, e_berr = 0;
    logic [31:0] e_adr = 0, e_dat = 0, e_rd = 0, m_rd = 0;
    logic [3:0]  e_sel = 0;

    always #5 clk_i = ~clk_i;

    rv32_wishbone_master #(.WB_REGION(4'h2), .TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_access_i(mem_access_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .write_data_i(write_data_i), .byte_en_i(byte_en_i), .stall_o(stall_o),
        .read_data_wishbone_o(read_data_wishbone_o), .bus_error_o(bus_error_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (chk_en) begin
        chk("stall", 32'(stall_o), 32'(e_stall));
        chk("cyc", 32'(wb_cyc_o), 32'(e_cyc));
        chk("stb", 32'(wb_stb_o), 32'(e_cyc));
        chk("bus_error", 32'(bus_error_o), 32'(e_berr));
        chk("rdata", read_data_wishbone_o, e_rd);
        if (e_cyc) begin
            chk("we", 32'(wb_we_o), 32'(e_we));
            chk("adr", wb_adr_o, e_adr);
            chk("dat", wb_dat_o, e_dat);
            chk("sel", 32'(wb_sel_o), 32'(e_sel));
        end
        if (stall_o) stall_cnt++;
    end

    // One instruction: w = BUS cycle index of the slave's response; w >= T means no response.
    task automatic txn(input bit acc, input logic [31:0] a, input bit we, input logic [31:0] d,
                       input logic [3:0] be, input int w, input bit err, input bit ack_too,
                       input logic [31:0] rd);
        bit hit  = acc && a[31:28] == 4'h2;
        int n    = (w < T) ? w + 1 : T;
        bit fail = (w < T) ? err : 1'b1;
        @(posedge clk_i); #1;
        mem_access_i = acc; mem_write_i = we; addr_i = a; write_data_i = d; byte_en_i = be;
        wb_ack_i = 0; wb_err_i = 0;
        e_stall = hit; e_cyc = 0; e_berr = 0; e_rd = m_rd;
        if (!hit) return;
        e_adr = {a[31:2], 2'b00}; e_dat = d; e_sel = we ? be : 4'hF; e_we = we;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
            e_cyc = 1; e_stall = 1;
            wb_ack_i = (k == w) && (!err || ack_too);
            wb_err_i = (k == w) && err;
            wb_dat_i = (k == w) ? rd : $urandom;
        end
        @(posedge clk_i); #1;
        wb_ack_i = 0; wb_err_i = 0;
        if (!we) m_rd = fail ? 32'h0 : rd;
        e_cyc = 0; e_stall = 0; e_berr = fail; e_rd = m_rd;
    endtask

    task automatic idle();
        txn(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rx;
        mem_access_i = 1; addr_i = 32'h2000_0000;
        #2;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_rdata", read_data_wishbone_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0; mem_access_i = 0; chk_en = 1;
        idle();

        stall_cnt = 0;
        txn(1, 32'h2000_0004, 0, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF);
        chk("load_stall_cycles", stall_cnt, 2);
        chk("load_rdata", read_data_wishbone_o, 32'hDEAD_BEEF);
        chk("load_adr", wb_adr_o, 32'h2000_0004);
        idle();

        stall_cnt = 0;
        txn(1, 32'h2000_0013, 1, 32'hAB00_0000, 4'b1000, 3, 0, 0, 32'h1234_5678);
        chk("store_stall_cycles", stall_cnt, 5);
        chk("store_rdata_kept", read_data_wishbone_o, 32'hDEAD_BEEF);
        chk("store_adr", wb_adr_o, 32'h2000_0010);
        chk("store_sel", 32'(wb_sel_o), 32'h8);

        stall_cnt = 0;
        txn(1, 32'h1000_0000, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
        txn(0, 32'h2000_0008, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0);
        idle();
        chk("miss_stall_cycles", stall_cnt, 0);

        stall_cnt = 0;
        txn(1, 32'h2000_0020, 0, 32'h0, 4'h0, 100, 0, 0, 32'h0);
        chk("timeout_stall_cycles", stall_cnt, T + 1);
        chk("timeout_berr", 32'(bus_error_o), 32'h1);
        chk("timeout_rdata", read_data_wishbone_o, 32'h0);
        idle();

        txn(1, 32'h2000_0040, 0, 32'h0, 4'h0, 1, 0, 0, 32'hCAFE_F00D);
        txn(1, 32'h2000_0055, 0, 32'h0, 4'h0, 1, 1, 1, 32'h0000_0055);
        chk("ack_err_berr", 32'(bus_error_o), 32'h1);
        chk("ack_err_rdata", read_data_wishbone_o, 32'h0);
        idle();

        @(posedge clk_i); #1;
        mem_access_i = 1; mem_write_i = 0; addr_i = 32'h2000_0100; write_data_i = 0;
        e_stall = 1; e_cyc = 0; e_berr = 0; e_rd = m_rd;
        e_adr = 32'h2000_0100; e_sel = 4'hF; e_we = 0; e_dat = 0;
        repeat (2) begin @(posedge clk_i); #1; e_cyc = 1; end
        chk_en = 0;
        #2 rst_i = 1;
        #1;
        chk("async_rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("async_rst_stb", 32'(wb_stb_o), 32'h0);
        chk("async_rst_stall", 32'(stall_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0; mem_access_i = 0; m_rd = 0;
        e_stall = 0; e_cyc = 0; e_berr = 0; e_rd = 0; chk_en = 1;
        stall_cnt = 0;
        txn(1, 32'h2000_0200, 0, 32'h0, 4'h0, 0, 0, 0, 32'h1111_2222);
        txn(1, 32'h2000_0204, 0, 32'h0, 4'h0, 1, 0, 0, 32'h3333_4444);
        idle();
        chk("b2b_stall_cycles", stall_cnt, 5);
        chk("b2b_rdata", read_data_wishbone_o, 32'h3333_4444);

        for (int i = 0; i < 60; i++) begin
            int r, w;
            r  = $urandom % 3;
            rx = $urandom;
            ra = (r == 0) ? {4'h2, rx[27:0]} : (r == 1) ? {4'h1, rx[27:0]} : rx;
            r  = $urandom % 8;
            w  = (r == 0) ? T + int'($urandom % 3) : (r == 1) ? T - 1 : int'($urandom % 5);
            txn(($urandom % 4) != 0, ra, $urandom % 2 == 1, $urandom, 4'($urandom),
                w, ($urandom % 6) == 0, $urandom % 2 == 1, $urandom);
            if ($urandom % 3 == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
